// File: rtl/req_pkg.sv
// req_pkg: shared types and constants for the memory request unit.
//   req_state_t : sequencer states (IDLE, FETCH, DECODE, DATA, DONE)
//   acc_t       : kind of data access latched in DECODE (read or write)
//   NOP_INSTR   : instruction presented after reset or after an abandoned fetch
//   is_mem_state: true for the states that drive an enable towards the RAM
package req_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DATA,
    DONE
  } req_state_t;

  typedef enum logic {
    ACC_READ,
    ACC_WRITE
  } acc_t;

  function automatic logic is_mem_state(input req_state_t s);
    return (s == FETCH) || (s == DATA);
  endfunction

endpackage

// File: rtl/busy_timer.sv
// busy_timer: counts consecutive stalled cycles of one RAM access.
// Ports:
//   clk     in  system clock, rising edge
//   nRST    in  asynchronous active-low reset
//   busy    in  RAM is stalling an access that is being presented this cycle
//   clear   in  restart the count (the sequencer is changing state)
//   expired out this cycle is the TIMEOUT-th consecutive busy cycle; the
//               access must be abandoned at the end of it
// TIMEOUT == 0 disables the timer: the count stays at zero, expired stays low.
module busy_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic busy,
  input  logic clear,
  output logic expired
);

  // The counter only has to hold 0..TIMEOUT-1: the busy cycle that would
  // reach TIMEOUT raises expired and the resulting state change clears it.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic ENABLED = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy && ENABLED) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = ENABLED && busy && (cnt_q == LAST);

endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit: sequences instruction fetch and the optional data access
// of a single-cycle core over one shared single-port RAM.
// Ports:
//   clk, nRST                 clock (rising edge), asynchronous active-low reset
//   imem_addr  in  DATA_W     PC; sampled live while fetching
//   imem_load  out DATA_W     held instruction, changes only when a fetch ends
//   i_ready    out 1          one-cycle pulse: instruction complete
//   d_read     in  1          memRead from control
//   d_write    in  1          memWrite from control (wins over d_read)
//   dmem_addr  in  DATA_W     data address, sampled live in DATA
//   dmem_store in  DATA_W     store data, sampled live in DATA
//   dmem_load  out DATA_W     held load data, changes only when a read ends
//   d_ready    out 1          one-cycle pulse (with i_ready): data access done
//   ram_addr   out DATA_W     RAM address (0 when no access)
//   ram_store  out DATA_W     RAM write data (0 unless writing)
//   ram_ren    out 1          RAM read enable
//   ram_wen    out 1          RAM write enable
//   ram_load   in  DATA_W     RAM read data, valid in the cycle ram_busy == 0
//   ram_busy   in  1          RAM stall
//   mem_err    out 1          sticky: some access was abandoned by the timer
//   dbg_state  out            current sequencer state
//
// RAM handshake: an access is requested for as long as ram_ren or ram_wen is
// high; it completes at the end of the first such cycle with ram_busy == 0,
// and ram_load is only looked at in that cycle. Completion pulses i_ready and
// d_ready are high for exactly one cycle (DONE) and carry no backpressure.
module mem_request_unit #(
  parameter int                 DATA_W    = 32,
  parameter int                 TIMEOUT   = 255,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(req_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic [DATA_W-1:0]     imem_addr,
  output logic [DATA_W-1:0]     imem_load,
  output logic                  i_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     dmem_addr,
  input  logic [DATA_W-1:0]     dmem_store,
  output logic [DATA_W-1:0]     dmem_load,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_store,
  output logic                  ram_ren,
  output logic                  ram_wen,
  input  logic [DATA_W-1:0]     ram_load,
  input  logic                  ram_busy,
  output logic                  mem_err,
  output req_pkg::req_state_t   dbg_state
);

  import req_pkg::*;

  req_state_t        state_q,     state_d;
  acc_t              acc_q,       acc_d;
  logic [DATA_W-1:0] imem_load_q, imem_load_d;
  logic [DATA_W-1:0] dmem_load_q, dmem_load_d;
  logic              did_data_q,  did_data_d;
  logic              mem_err_q,   mem_err_d;

  logic timer_busy;
  logic timer_clear;
  logic timer_expired;

  // Only stalls of an access actually being presented count towards timeout.
  assign timer_busy  = ram_busy && is_mem_state(state_q);
  assign timer_clear = (state_d != state_q);

  busy_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_busy_timer (
    .clk     (clk),
    .nRST    (nRST),
    .busy    (timer_busy),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  // Next-state and held-data update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    imem_load_d = imem_load_q;
    dmem_load_d = dmem_load_q;
    did_data_d  = did_data_q;
    mem_err_d   = mem_err_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (!ram_busy) begin
          imem_load_d = ram_load;
          state_d     = DECODE;
        end else if (timer_expired) begin
          // Abandoned fetch executes as a NOP so the core keeps stepping.
          imem_load_d = NOP_INSTR;
          mem_err_d   = 1'b1;
          state_d     = DECODE;
        end
      end

      DECODE: begin
        // Store has priority; a simultaneous read request is dropped.
        if (d_write) begin
          acc_d   = ACC_WRITE;
          state_d = DATA;
        end else if (d_read) begin
          acc_d   = ACC_READ;
          state_d = DATA;
        end else begin
          state_d = DONE;
        end
      end

      DATA: begin
        if (!ram_busy) begin
          if (acc_q == ACC_READ) begin
            dmem_load_d = ram_load;
          end
          did_data_d = 1'b1;
          state_d    = DONE;
        end else if (timer_expired) begin
          // Abandoned data access still reports completion so the core moves on.
          dmem_load_d = '0;
          did_data_d  = 1'b1;
          mem_err_d   = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        did_data_d = 1'b0;
        state_d    = FETCH;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      acc_q       <= ACC_READ;
      imem_load_q <= NOP_INSTR;
      dmem_load_q <= '0;
      did_data_q  <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      imem_load_q <= imem_load_d;
      dmem_load_q <= dmem_load_d;
      did_data_q  <= did_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // RAM-side outputs are decoded from the registered state, so an
  // asynchronous reset drops both enables in the same cycle.
  always_comb begin
    ram_addr  = '0;
    ram_store = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    case (state_q)
      FETCH: begin
        ram_ren  = 1'b1;
        ram_addr = imem_addr;
      end
      DATA: begin
        ram_addr = dmem_addr;
        if (acc_q == ACC_WRITE) begin
          ram_wen   = 1'b1;
          ram_store = dmem_store;
        end else begin
          ram_ren   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign imem_load = imem_load_q;
  assign dmem_load = dmem_load_q;
  assign i_ready   = (state_q == DONE);
  assign d_ready   = (state_q == DONE) && did_data_q;
  assign mem_err   = mem_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed bench for mem_request_unit (TIMEOUT = 4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_mem_request_unit;

  import req_pkg::*;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] imem_addr, imem_load, dmem_addr, dmem_store, dmem_load;
  logic [DATA_W-1:0] ram_addr, ram_store, ram_load;
  logic              i_ready, d_read, d_write, d_ready, ram_ren, ram_wen, ram_busy, mem_err;
  req_state_t        dbg_state;

  mem_request_unit #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .nRST       (nRST),
    .imem_addr  (imem_addr),
    .imem_load  (imem_load),
    .i_ready    (i_ready),
    .d_read     (d_read),
    .d_write    (d_write),
    .dmem_addr  (dmem_addr),
    .dmem_store (dmem_store),
    .dmem_load  (dmem_load),
    .d_ready    (d_ready),
    .ram_addr   (ram_addr),
    .ram_store  (ram_store),
    .ram_ren    (ram_ren),
    .ram_wen    (ram_wen),
    .ram_load   (ram_load),
    .ram_busy   (ram_busy),
    .mem_err    (mem_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];      // expected instruction per completed instruction
  logic [DATA_W-1:0] exp_imem = NOP_INSTR;
  logic [DATA_W-1:0] exp_dmem = '0;
  logic              exp_err  = 1'b0;

  // Cycles since the previous i_ready pulse, measured on the DUT outputs.
  int since_ready;
  always @(posedge clk or negedge nRST) begin
    if (!nRST)        since_ready <= -1;
    else if (i_ready) since_ready <= 0;
    else              since_ready <= since_ready + 1;
  end

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Drives one instruction starting in a FETCH cycle and ends at the next FETCH.
  task automatic run_instr(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] instr,
                           input int f_busy, input logic rd, input logic wr,
                           input logic [DATA_W-1:0] daddr, input logic [DATA_W-1:0] sdata,
                           input logic [DATA_W-1:0] ldata, input int d_busy,
                           input int exp_lat);
    int  n_cyc;
    logic f_to, d_to, bsy;
    f_to = (f_busy >= TIMEOUT);
    d_to = (d_busy >= TIMEOUT);
    // FETCH
    imem_addr = pc; d_read = 1'b0; d_write = 1'b0;
    n_cyc = f_to ? TIMEOUT : f_busy + 1;
    for (int i = 0; i < n_cyc; i++) begin
      bsy      = (i < f_busy);
      ram_busy = bsy;
      ram_load = bsy ? DATA_W'($urandom) : instr;
      #1;
      check_val("fetch_ren",  ram_ren,   1'b1);
      check_val("fetch_wen",  ram_wen,   1'b0);
      check_val("fetch_addr", ram_addr,  pc);
      check_val("fetch_hold", imem_load, exp_imem);
      check_val("fetch_err",  mem_err,   exp_err);
      next_cycle();
    end
    exp_imem = f_to ? NOP_INSTR : instr;
    if (f_to) exp_err = 1'b1;
    exp_q.push_back(exp_imem);
    // DECODE
    ram_busy = 1'b0; ram_load = DATA_W'($urandom);
    d_read = rd; d_write = wr; dmem_addr = daddr; dmem_store = sdata;
    #1;
    check_val("dec_imem",  imem_load, exp_imem);
    check_val("dec_en",    {ram_ren, ram_wen}, 2'b00);
    check_val("dec_addr",  ram_addr, '0);
    check_val("dec_rdy",   i_ready,  1'b0);
    check_val("dec_err",   mem_err,  exp_err);
    next_cycle();
    // DATA
    if (rd || wr) begin
      n_cyc = d_to ? TIMEOUT : d_busy + 1;
      for (int i = 0; i < n_cyc; i++) begin
        bsy      = (i < d_busy);
        ram_busy = bsy;
        ram_load = bsy ? DATA_W'($urandom) : ldata;
        #1;
        check_val("data_wen",   ram_wen,   wr);
        check_val("data_ren",   ram_ren,   !wr);
        check_val("data_addr",  ram_addr,  daddr);
        check_val("data_store", ram_store, wr ? sdata : '0);
        check_val("data_hold",  dmem_load, exp_dmem);
        check_val("data_err",   mem_err,   exp_err);
        next_cycle();
      end
      if (d_to)     exp_dmem = '0;
      else if (!wr) exp_dmem = ldata;
      if (d_to) exp_err = 1'b1;
    end
    // DONE
    ram_busy = 1'b0;
    #1;
    check_val("done_irdy", i_ready,   1'b1);
    check_val("done_drdy", d_ready,   rd || wr);
    check_val("done_imem", imem_load, exp_q.pop_front());
    check_val("done_dmem", dmem_load, exp_dmem);
    check_val("done_err",  mem_err,   exp_err);
    check_val("done_en",   {ram_ren, ram_wen}, 2'b00);
    check_val("latency",   since_ready + 1, exp_lat);
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0; imem_addr = '0; d_read = 1'b0; d_write = 1'b0;
    dmem_addr = '0; dmem_store = '0; ram_load = '0; ram_busy = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    check_val("rst_imem",  imem_load, NOP_INSTR);
    check_val("rst_dmem",  dmem_load, '0);
    check_val("rst_rdy",   {i_ready, d_ready}, 2'b00);
    check_val("rst_en",    {ram_ren, ram_wen}, 2'b00);
    check_val("rst_addr",  ram_addr, '0);
    check_val("rst_store", ram_store, '0);
    check_val("rst_err",   mem_err, 1'b0);
    nRST = 1'b1;
    #1;
    check_val("idle_ren",   ram_ren, 1'b0);
    check_val("idle_state", dbg_state, IDLE);
    next_cycle();

    //        pc        instr         fb rd    wr    daddr     sdata         ldata         db  lat
    run_instr(32'h0000, 32'h00500093, 0, 1'b0, 1'b0, 32'h000, 32'h0,        32'h0,        0,  3);
    run_instr(32'h0004, 32'h10002083, 0, 1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 2,  6);
    run_instr(32'h0008, 32'h10502223, 0, 1'b0, 1'b1, 32'h104, 32'h12345678, 32'h0,        0,  4);
    run_instr(32'h000C, 32'h10802423, 0, 1'b1, 1'b1, 32'h108, 32'hCAFEF00D, 32'h0,        0,  4);
    run_instr(32'h0010, 32'h0000A103, 3, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'h0BADF00D, 1,  8);
    run_instr(32'h0014, 32'h20002183, 0, 1'b1, 1'b0, 32'h200, 32'h0,        32'h11111111, 10, 7);
    run_instr(32'h0018, 32'h00100113, 0, 1'b0, 1'b0, 32'h000, 32'h0,        32'h0,        0,  3);
    run_instr(32'h001C, 32'hFFFFFFFF, 9, 1'b0, 1'b0, 32'h000, 32'h0,        32'h0,        0,  6);

    // Reset in the middle of a stalled store.
    imem_addr = 32'h20; ram_busy = 1'b0; ram_load = 32'h0020A023;
    next_cycle();
    d_write = 1'b1; dmem_addr = 32'h200; dmem_store = 32'h55AA55AA;
    next_cycle();
    ram_busy = 1'b1;
    #1;
    check_val("mid_wen",  ram_wen, 1'b1);
    #1;
    nRST = 1'b0;
    #1;
    check_val("arst_en",    {ram_ren, ram_wen}, 2'b00);
    check_val("arst_addr",  ram_addr, '0);
    check_val("arst_store", ram_store, '0);
    check_val("arst_rdy",   {i_ready, d_ready}, 2'b00);
    check_val("arst_imem",  imem_load, NOP_INSTR);
    check_val("arst_dmem",  dmem_load, '0);
    check_val("arst_err",   mem_err, 1'b0);
    next_cycle();
    nRST = 1'b1; ram_busy = 1'b0; d_write = 1'b0;
    #1;
    check_val("rel_idle_ren", ram_ren, 1'b0);
    next_cycle();
    #1;
    check_val("rel_fetch_ren",  ram_ren, 1'b1);
    check_val("rel_fetch_addr", ram_addr, 32'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
